// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  // Cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Occupancy needs one extra bit so that "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Parity over the low n bits of a word; odd parity inverts the XOR.
  function automatic logic calc_parity(input logic [8:0] d, input int n, input parity_e mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < n) x = x ^ d[i];
    end
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port of the transmitter.
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready; the
// producer holds wr_data stable while wr_valid is high and wr_ready is low.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with valid/ready push and a pop strobe.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (level != LW'(DEPTH));
  assign empty      = (level == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop serialiser
// that streams queued words back to back with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            CLK100MHZ,
  input  logic                            fpga_rst,
  uart_tx_fifo_if.slave                   wr,
  output logic                            tx,
  output logic                            busy,
  output logic [level_w(FIFO_DEPTH)-1:0]  fifo_level,
  output tx_state_e                       state
);

  localparam int      DIV   = calc_div(CLK_HZ, BAUD);
  localparam int      CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int      BW    = $clog2(DATA_BITS);
  localparam parity_e PMODE = parity_e'(2'(PARITY));

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 frame_end;

  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK100MHZ),
    .rst        (fpga_rst),
    .push_valid (wr.wr_valid),
    .push_data  (wr.wr_data),
    .push_ready (wr.wr_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  assign frame_end = (state == ST_STOP) && (baud_cnt == '0) && (stop_cnt == 1'b0);
  assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || frame_end);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  // tx is registered from the current state, so the line trails the FSM by one
  // cycle; every bit still lasts exactly DIV cycles.
  always_ff @(posedge CLK100MHZ) begin
    if (fpga_rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        ST_START: tx <= 1'b0;
        ST_DATA:  tx <= shreg[0];
        ST_PAR:   tx <= par_bit;
        default:  tx <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_data;
            par_bit  <= calc_parity(9'(fifo_data), DATA_BITS, PMODE);
            baud_cnt <= CW'(DIV - 1);
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= CW'(DIV - 1);
            bit_cnt  <= BW'(DATA_BITS - 1);
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= CW'(DIV - 1);
            shreg    <= shreg >> 1;
            stop_cnt <= 1'(STOP_BITS - 1);
            if (bit_cnt == '0) begin
              state <= (PMODE != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_PAR: begin
          if (baud_cnt == '0) begin
            baud_cnt <= CW'(DIV - 1);
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            baud_cnt <= CW'(DIV - 1);
            if (stop_cnt != 1'b0) begin
              stop_cnt <= 1'b0;
            end else if (!fifo_empty) begin
              // Next word goes straight into its start bit.
              shreg   <= fifo_data;
              par_bit <= calc_parity(9'(fifo_data), DATA_BITS, PMODE);
              state   <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an input FIFO, driven from the 100 MHz board clock.
- Generalises the fixed-format serial stimulus currently used on the board's uart_rx line.
- Configurable baud rate, data width, parity, stop bits and FIFO depth; back-to-back frames with no idle gap.
- Used both as a synthesizable debug/console TX in top and as the bench-side driver of the DUT's uart_rx.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIV = (CLK_HZ + BAUD/2) / BAUD (868 at defaults). DIV must be >= 2.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, >= 2.

Ports:
- CLK100MHZ  in   1                        system clock, rising edge.
- fpga_rst   in   1                        synchronous, active-high reset.
- wr_valid   in   1                        write request.
- wr_data    in   DATA_BITS                byte to transmit.
- wr_ready   out  1                        FIFO can accept; high when level < FIFO_DEPTH.
- tx         out  1                        serial line, idles high, registered.
- busy       out  1                        FSM not IDLE or FIFO non-empty.
- fifo_level out  clog2(FIFO_DEPTH)+1      current FIFO occupancy.

Behaviour:
- Reset (fpga_rst sampled high at a clock edge): tx=1, busy=0, fifo_level=0, wr_ready=1; FSM to IDLE; FIFO pointers cleared.
- Reset mid-frame aborts the frame: tx=1 from the next cycle, and FIFO contents are discarded.
- Write handshake: an entry is accepted on an edge where wr_valid & wr_ready. No overflow is possible.
- With wr_valid high and wr_ready low, the data is held by the producer and nothing is written.
- FIFO is a circular buffer with wrapping pointers. fifo_level is updated on the same edge as a push or pop.
- A simultaneous push and pop leaves the level unchanged. When full, wr_ready=0, so a push cannot coincide with full; a pop on that edge raises wr_ready on the next cycle.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if FIFO non-empty, pop into the shift register, load bit counter, go to START. tx=1 while in IDLE.
- Latency: a byte accepted at edge N into an empty FIFO in IDLE gives tx=0 (start bit) after edge N+2.
- Every bit is held for exactly DIV cycles, using a baud counter reloaded at each bit boundary.
- START: tx=0, then DATA.
- DATA: DATA_BITS bits, LSB first, then PAR if PARITY != 0, else STOP.
- PAR: tx = XOR of data bits for even parity, inverted XOR for odd parity.
- STOP: tx=1 for STOP_BITS*DIV cycles.
- At the end of STOP: if FIFO non-empty, pop and go directly to START (zero idle cycles between frames); else go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- Parity is computed from the popped word, not from the live shift register.
- busy falls on the same cycle the FSM enters IDLE with the FIFO empty.

Decomposition:
- Shared package uart_pkg holds:
  - parity enum PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state typedef;
  - DIV computation function;
  - width helper for fifo_level.
- One natural sub-module, sync_fifo (parametrised width/depth, valid/ready push, pop strobe, level output), instantiated for the buffer.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- Single byte: CLK_HZ=1000, BAUD=100 (DIV=10), 8N1, write 0x55 at edge N.
  - tx=0 after N+2 for 10 cycles, then 1,0,1,0,1,0,1,0 with 10 cycles each, then 1 for 10 cycles.
  - busy=0 afterwards, frame total 100 cycles.
- Even parity, 8E1, write 0x07: parity bit = 1, frame 110 cycles. Odd parity, 8O1, write 0x07: parity bit = 0.
- 7 data bits, 2 stop bits, no parity, write 0x7F:
  - start, seven 1 bits, tx=1 for 20 cycles after data;
  - total 100 cycles.
- FIFO full and back-to-back:
  - hold wr_valid for 20 writes 0x00..0x13 with DEPTH=16;
  - wr_ready falls at fifo_level=16, and the stalled writes are accepted in order as frames drain;
  - all 20 frames are emitted consecutively with zero idle cycles and matching data.
- Reset mid-frame: assert fpga_rst for 1 cycle during data bit 3 with 4 entries queued.
  - tx=1 next cycle, fifo_level=0, busy=0;
  - no further frames;
  - a new write afterwards transmits normally.
